// File: rtl/vx_data_access_sched_pkg.sv
// Shared types and helpers for the per-bank data-store scheduler.
// The response struct below uses the default line/tag widths; parameterised users pass their own type.
package vx_data_access_sched_pkg;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } sched_state_e;

    localparam int DEF_LINE_SIZE = 64;
    localparam int DEF_TAG_WIDTH = 8;

    // Line-select width: log2 of the bank depth, never narrower than one bit.
    function automatic int calc_lsb(input int lines);
        return ($clog2(lines) < 1) ? 1 : $clog2(lines);
    endfunction

    typedef struct packed {
        logic [DEF_LINE_SIZE*8-1:0] data;
        logic [DEF_TAG_WIDTH-1:0]   tag;
    } rsp_t;

endpackage

// File: rtl/vx_data_access_rsp_buf.sv
// Two-entry read-response FIFO with occupancy count.
// Push and pop may coincide, including when full (the popped slot is the one being refilled).
module vx_data_access_rsp_buf
    import vx_data_access_sched_pkg::*;
#(
    parameter type entry_t = rsp_t
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       push_i,
    input  entry_t     push_data_i,
    input  logic       pop_i,
    output entry_t     head_o,
    output logic       empty_o,
    output logic [1:0] count_o
);

    entry_t     mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop_i) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + {1'b0, push_i} - {1'b0, pop_i};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage needs no reset; validity is tracked by count_q alone.
    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/vx_data_access_sched.sv
// Per-bank scheduler for the single-port cache data store: init sweep, fill/core arbitration
// with a bounded fill streak, one-cycle read tracking and a two-entry response buffer.
module vx_data_access_sched
    import vx_data_access_sched_pkg::*;
#(
    parameter int CACHE_LINE_SIZE = DEF_LINE_SIZE,
    parameter int LINES_PER_BANK  = 64,
    parameter int TAG_WIDTH       = DEF_TAG_WIDTH,
    parameter int FILL_STREAK     = 4,
    localparam int LSB            = calc_lsb(LINES_PER_BANK),
    localparam int DATA_W         = CACHE_LINE_SIZE * 8
) (
    input  logic                       clk,
    input  logic                       reset,

    input  logic                       fill_valid,
    input  logic [LSB-1:0]             fill_addr,
    input  logic [DATA_W-1:0]          fill_data,
    output logic                       fill_ready,

    input  logic                       creq_valid,
    input  logic                       creq_rw,
    input  logic [LSB-1:0]             creq_addr,
    input  logic [CACHE_LINE_SIZE-1:0] creq_byteen,
    input  logic [DATA_W-1:0]          creq_data,
    input  logic [TAG_WIDTH-1:0]       creq_tag,
    output logic                       creq_ready,

    output logic                       crsp_valid,
    output logic [DATA_W-1:0]          crsp_data,
    output logic [TAG_WIDTH-1:0]       crsp_tag,
    input  logic                       crsp_ready,

    output logic [LSB-1:0]             ram_addr,
    output logic                       ram_readen,
    output logic                       ram_writeen,
    output logic                       ram_is_fill,
    output logic [CACHE_LINE_SIZE-1:0] ram_byteen,
    output logic [DATA_W-1:0]          ram_wdata,
    input  logic [DATA_W-1:0]          ram_rdata,

    output logic                       init_done
);

    localparam int STREAK_W          = $clog2(FILL_STREAK + 1);
    localparam logic [LSB-1:0] LAST_LINE = LSB'(LINES_PER_BANK - 1);

    typedef struct packed {
        logic [DATA_W-1:0]    data;
        logic [TAG_WIDTH-1:0] tag;
    } rsp_line_t;

    sched_state_e         state_q, state_d;
    logic [LSB-1:0]       sweep_q, sweep_d;
    logic [STREAK_W-1:0]  streak_q, streak_d;
    logic                 inflight_q, inflight_d;
    logic [TAG_WIDTH-1:0] tag_q, tag_d;

    rsp_line_t  fifo_head;
    rsp_line_t  push_entry;
    logic       fifo_empty;
    logic [1:0] fifo_count;
    logic       fifo_pop;
    logic       fifo_push;

    logic [2:0] occupancy;
    logic       read_ok;
    logic       streak_full;
    logic       core_elig;
    logic       grant_fill;
    logic       grant_core;

    // Read data lands one cycle after the strobe and is buffered with the latched tag.
    assign fifo_push  = inflight_q;
    assign fifo_pop   = !fifo_empty && crsp_ready;
    assign push_entry = '{data: ram_rdata, tag: tag_q};

    // A read may issue only if its response is guaranteed a FIFO slot.
    assign occupancy   = 3'(fifo_count) + 3'(inflight_q);
    assign read_ok     = (occupancy < 3'd2) || ((occupancy == 3'd2) && fifo_pop);
    assign streak_full = (streak_q == STREAK_W'(FILL_STREAK));

    always_comb begin
        core_elig  = 1'b0;
        grant_fill = 1'b0;
        grant_core = 1'b0;
        if (state_q == ST_RUN) begin
            core_elig = creq_valid && (creq_rw || read_ok);
            if (fill_valid && !(core_elig && streak_full)) begin
                grant_fill = 1'b1;
            end else if (core_elig) begin
                grant_core = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        streak_d    = streak_q;
        inflight_d  = 1'b0;
        tag_d       = tag_q;
        fill_ready  = 1'b0;
        creq_ready  = 1'b0;
        ram_addr    = '0;
        ram_readen  = 1'b0;
        ram_writeen = 1'b0;
        ram_is_fill = 1'b0;
        ram_byteen  = '0;
        ram_wdata   = '0;

        case (state_q)
            ST_INIT: begin
                ram_writeen = 1'b1;
                ram_is_fill = 1'b1;
                ram_byteen  = '1;
                ram_addr    = sweep_q;
                sweep_d     = sweep_q + 1'b1;
                if (sweep_q == LAST_LINE) begin
                    state_d = ST_RUN;
                end
            end

            ST_RUN: begin
                if (grant_fill) begin
                    fill_ready  = 1'b1;
                    ram_writeen = 1'b1;
                    ram_is_fill = 1'b1;
                    ram_byteen  = '1;
                    ram_addr    = fill_addr;
                    ram_wdata   = fill_data;
                end else if (grant_core) begin
                    creq_ready = 1'b1;
                    ram_addr   = creq_addr;
                    if (creq_rw) begin
                        ram_writeen = 1'b1;
                        ram_byteen  = creq_byteen;
                        ram_wdata   = creq_data;
                    end else begin
                        ram_readen = 1'b1;
                        inflight_d = 1'b1;
                        tag_d      = creq_tag;
                    end
                end

                // Streak only counts fills that actually held off an eligible core request.
                if (grant_core || !creq_valid) begin
                    streak_d = '0;
                end else if (grant_fill && core_elig && !streak_full) begin
                    streak_d = streak_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_INIT;
            sweep_q    <= '0;
            streak_q   <= '0;
            inflight_q <= 1'b0;
            tag_q      <= '0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            streak_q   <= streak_d;
            inflight_q <= inflight_d;
            tag_q      <= tag_d;
        end
    end

    vx_data_access_rsp_buf #(
        .entry_t (rsp_line_t)
    ) u_rsp_buf (
        .clk         (clk),
        .reset       (reset),
        .push_i      (fifo_push),
        .push_data_i (push_entry),
        .pop_i       (fifo_pop),
        .head_o      (fifo_head),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

    assign crsp_valid = !fifo_empty;
    assign crsp_data  = fifo_head.data;
    assign crsp_tag   = fifo_head.tag;
    assign init_done  = (state_q == ST_RUN);

endmodule

// File: doc/vx_data_access_sched.md
Name: vx_data_access_sched

Overview:
Per-bank scheduler in front of the single-port cache data store. It arbitrates between memory fill writes and core read/write requests, and issues at most one RAM operation per cycle. It also tracks the 1-cycle read latency and buffers read responses against core back-pressure. After reset it runs an init sweep that zeroes every line before accepting traffic.

Parameters:
CACHE_LINE_SIZE, 64, line size in bytes; RAM data width = CACHE_LINE_SIZE*8
LINES_PER_BANK, 64, lines in the bank; LSB = max(1, clog2(LINES_PER_BANK)) address bits
TAG_WIDTH, 8, opaque core request tag returned with read data
FILL_STREAK, 4, max consecutive fill grants while a core request waits (must be >= 1)

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
fill_valid  in  1  fill request valid
fill_addr  in  LSB  fill line select
fill_data  in  CACHE_LINE_SIZE*8  fill line data
fill_ready  out  1  fill accepted this cycle
creq_valid  in  1  core request valid
creq_rw  in  1  1 = write, 0 = read
creq_addr  in  LSB  core line select
creq_byteen  in  CACHE_LINE_SIZE  write byte enables
creq_data  in  CACHE_LINE_SIZE*8  write data
creq_tag  in  TAG_WIDTH  request tag
creq_ready  out  1  core request accepted this cycle
crsp_valid  out  1  read response valid
crsp_data  out  CACHE_LINE_SIZE*8  read data
crsp_tag  out  TAG_WIDTH  tag of read
crsp_ready  in  1  core takes response
ram_addr  out  LSB  to data store
ram_readen  out  1  read strobe
ram_writeen  out  1  write strobe
ram_is_fill  out  1  full-line write
ram_byteen  out  CACHE_LINE_SIZE  write byte enables
ram_wdata  out  CACHE_LINE_SIZE*8  write data
ram_rdata  in  CACHE_LINE_SIZE*8  data store output, valid the cycle after ram_readen
init_done  out  1  init sweep complete

Behaviour:
- Reset (synchronous, active-high): state = INIT, sweep counter = 0, streak = 0, response FIFO empty, in-flight bit = 0. Outputs: fill_ready = 0, creq_ready = 0, crsp_valid = 0, init_done = 0, ram_readen = 0.
- Reset asserted mid-operation discards any in-flight read and all buffered responses. The sweep restarts.
- INIT state: each cycle drives ram_writeen = 1, ram_is_fill = 1, ram_byteen = all ones, ram_wdata = 0, ram_addr = counter. The counter increments by 1.
- INIT exit: when counter = LINES_PER_BANK-1 and that write has issued, go to RUN on the next cycle and set init_done = 1. INIT takes exactly LINES_PER_BANK cycles.
- RUN state never returns to INIT except via reset.
- Arbitration in RUN, one grant per cycle, purely combinational on the current inputs:
  - Fill wins over core unless streak = FILL_STREAK and creq_valid = 1 (core eligible); in that case core wins.
  - Streak increments on a fill grant while creq_valid = 1, saturating at FILL_STREAK.
  - Streak resets to 0 on a core grant, or on any cycle where creq_valid = 0.
- Core read eligibility: allowed only if (fifo_count + inflight) < 2, or if that sum is 2 and a FIFO pop occurs this cycle. Core writes are always eligible.
- If the core is not eligible, fill gets the grant and streak does not increment.
- Fill grant: fill_ready = 1. Drive ram_writeen = 1, ram_is_fill = 1, ram_byteen = all ones, ram_addr = fill_addr, ram_wdata = fill_data.
- Core write grant: creq_ready = 1. Drive ram_writeen = 1, ram_is_fill = 0, ram_byteen = creq_byteen, ram_wdata = creq_data. No response is generated.
- Core read grant: creq_ready = 1, ram_readen = 1. Set inflight; latch the tag.
- Read completion: on the next cycle, push {ram_rdata, tag} into the 2-entry response FIFO and clear inflight, unless a new read is issued in the same cycle.
- Response FIFO: crsp_valid = not empty; head is presented on crsp_data/crsp_tag. Pop when crsp_valid && crsp_ready. Push and pop in the same cycle are allowed, including when the FIFO is full. Responses leave in issue order.
- Read-after-write to the same line in consecutive cycles returns the new data; the data store provides the RWCHECK ordering.
- ram_addr, ram_wdata and ram_byteen are don't-care when neither strobe is set; drive 0.

Decomposition:
- Shared package holds: state enum (INIT, RUN), LSB calculation, and a response struct {data, tag}.
- One sub-module: vx_data_access_rsp_buf, the 2-entry FIFO with count and simultaneous push/pop.

Test Plan:
- Reset, LINES_PER_BANK=64 -> 64 zero full-line writes to addresses 0..63; init_done rises on cycle 65; fill_ready and creq_ready stay 0 throughout.
- Fill line 5 = 0xAA.., then core read line 5 with tag 0x3 -> crsp_valid 2 cycles after the read grant with data 0xAA.. and tag 0x3.
- Core write byteen = 0x1 with 0x11 to line 5, then read line 5 -> byte 0 = 0x11, remaining bytes 0xAA.
- fill_valid and creq_valid held high together with FILL_STREAK=4 -> grant pattern F,F,F,F,C repeating.
- crsp_ready = 0 with 4 back-to-back reads -> exactly 2 reads granted, then creq_ready = 0. Release crsp_ready -> remaining reads granted; tags return in order with no loss.
- Reset asserted with a read in flight and FIFO full -> crsp_valid = 0 the next cycle and the INIT sweep restarts at address 0.
